game_soc_multi_timer: RTL and testbench

//  Parametrised multi-channel interval timer on one Avalon-MM 16-bit slave with a single shared irq.

---
 rtl/game_soc_multi_timer_pkg.sv | 25 ++
 rtl/game_soc_multi_timer_channel.sv | 141 ++++++++++++++
 rtl/game_soc_multi_timer.sv | 81 ++++++++
 tb/tb_game_soc_multi_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_soc_multi_timer_pkg.sv
// Shared register map and control/status bit positions for the game_soc multi-channel timer.
package game_soc_multi_timer_pkg;

  localparam logic [3:0] REG_STATUS   = 4'd0;
  localparam logic [3:0] REG_CONTROL  = 4'd1;
  localparam logic [3:0] REG_PERIOD0  = 4'd2;
  localparam logic [3:0] REG_SNAP0    = 4'd6;
  localparam logic [3:0] REG_SNAP3    = 4'd9;
  localparam logic [3:0] REG_PRESCALE = 4'd10;
  localparam logic [3:0] REG_IRQ_PEND = 4'd11;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Register offset of halfword hw inside a multi-halfword register group.
  function automatic logic [3:0] hw_offset(input logic [3:0] base, input int hw);
    return base + 4'(hw);
  endfunction

endpackage

// File: rtl/game_soc_multi_timer_channel.sv
// One timer channel: prescaler, down-counter with reload, control/status, period and snapshot
// registers, plus the combinational 16-bit read mux for register offsets 0..10.
module game_soc_multi_timer_channel
  import game_soc_multi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE_W   = 8,
  parameter logic [63:0] RESET_PERIOD = 64'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [3:0]  offset_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        irq_pend_o
);

  localparam int                    NHW     = CNT_W / 16;
  localparam logic [CNT_W-1:0]      RST_VAL = RESET_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] PC_ONE  = PRESCALE_W'(1);

  logic                  run_q, run_d;
  logic                  to_q, to_d;
  logic                  ito_q, ito_d;
  logic                  cont_q, cont_d;
  logic                  force_reload_q, force_reload_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [CNT_W-1:0]      snap_q, snap_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;

  logic status_wr, ctrl_wr, prescale_wr, snap_wr;
  logic tick, at_zero;

  always_comb begin
    status_wr   = wr_en_i && (offset_i == REG_STATUS);
    ctrl_wr     = wr_en_i && (offset_i == REG_CONTROL);
    prescale_wr = wr_en_i && (offset_i == REG_PRESCALE);
    snap_wr     = wr_en_i && (offset_i >= REG_SNAP0) && (offset_i <= REG_SNAP3);
    at_zero     = (counter_q == '0);
    tick        = run_q && (pc_q == '0);

    run_d          = run_q;
    to_d           = to_q;
    ito_d          = ito_q;
    cont_d         = cont_q;
    force_reload_d = 1'b0;
    period_d       = period_q;
    counter_d      = counter_q;
    snap_d         = snap_q;
    prescale_d     = prescale_q;
    pc_d           = pc_q;

    // Halfwords beyond the counter width do not exist: no store and no reload.
    for (int h = 0; h < NHW; h++) begin
      if (wr_en_i && (offset_i == hw_offset(REG_PERIOD0, h))) begin
        period_d[h*16 +: 16] = wdata_i;
        force_reload_d       = 1'b1;
      end
    end
    if (prescale_wr) prescale_d = wdata_i[PRESCALE_W-1:0];
    if (snap_wr)     snap_d     = counter_q;
    if (ctrl_wr) begin
      ito_d  = wdata_i[CTRL_ITO];
      cont_d = wdata_i[CTRL_CONT];
    end

    if (run_q) pc_d = tick ? prescale_q : pc_q - PC_ONE;
    if (tick) begin
      if (at_zero) begin
        counter_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        counter_d = counter_q - CNT_ONE;
      end
    end
    if (force_reload_q) begin
      counter_d = period_q;
      pc_d      = prescale_q;
      run_d     = 1'b0;
    end
    // START is applied last so it overrides every source of stopping.
    if (ctrl_wr && wdata_i[CTRL_STOP])  run_d = 1'b0;
    if (ctrl_wr && wdata_i[CTRL_START]) run_d = 1'b1;

    to_d = to_q | ((counter_d == '0) && !at_zero);
    if (status_wr) to_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q          <= 1'b0;
      to_q           <= 1'b0;
      ito_q          <= 1'b0;
      cont_q         <= 1'b0;
      force_reload_q <= 1'b0;
      period_q       <= RST_VAL;
      counter_q      <= RST_VAL;
      snap_q         <= '0;
      prescale_q     <= '0;
      pc_q           <= '0;
    end else begin
      run_q          <= run_d;
      to_q           <= to_d;
      ito_q          <= ito_d;
      cont_q         <= cont_d;
      force_reload_q <= force_reload_d;
      period_q       <= period_d;
      counter_q      <= counter_d;
      snap_q         <= snap_d;
      prescale_q     <= prescale_d;
      pc_q           <= pc_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (offset_i)
      REG_STATUS: begin
        rdata_o[STAT_TO]  = to_q;
        rdata_o[STAT_RUN] = run_q;
      end
      REG_CONTROL: begin
        rdata_o[CTRL_ITO]  = ito_q;
        rdata_o[CTRL_CONT] = cont_q;
      end
      REG_PRESCALE: rdata_o = 16'(prescale_q);
      default: ;
    endcase
    for (int h = 0; h < NHW; h++) begin
      if (offset_i == hw_offset(REG_PERIOD0, h)) rdata_o = period_q[h*16 +: 16];
      if (offset_i == hw_offset(REG_SNAP0, h))   rdata_o = snap_q[h*16 +: 16];
    end
  end

  assign irq_pend_o = to_q & ito_q;

endmodule

// File: rtl/game_soc_multi_timer.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave: channel decode, registered read
// data with one clock of latency, and a single OR-reduced interrupt line.
module game_soc_multi_timer
  import game_soc_multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE_W   = 8,
  parameter logic [63:0] RESET_PERIOD = 64'd49999,
  localparam int         AW           = $clog2(NUM_CH) + 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [15:0]   writedata,
  output logic [15:0]   readdata,
  output logic          irq
);

  logic [3:0]        ch_idx;
  logic [3:0]        offset;
  logic              ch_valid;
  logic              wr;
  logic [15:0]       ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [15:0]       readdata_q, readdata_d;

  assign offset = address[3:0];

  generate
    if (AW > 4) begin : g_chsel
      assign ch_idx = 4'(address[AW-1:4]);
    end else begin : g_chsel_single
      assign ch_idx = 4'd0;
    end
  endgenerate

  // Channel windows past NUM_CH are holes in the map: no writes land, reads give zero.
  assign ch_valid = (ch_idx < 4'(NUM_CH));
  assign wr       = chipselect && !write_n && ch_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    game_soc_multi_timer_channel #(
      .CNT_W        (CNT_W),
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en_i    (wr && (ch_idx == 4'(i))),
      .offset_i   (offset),
      .wdata_i    (writedata),
      .rdata_o    (ch_rdata[i]),
      .irq_pend_o (pend[i])
    );
  end

  always_comb begin
    readdata_d = '0;
    if (ch_valid) begin
      if (offset == REG_IRQ_PEND) begin
        readdata_d = 16'(pend);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) readdata_d = ch_rdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |pend;

endmodule

// File: tb/tb_game_soc_multi_timer.sv
// Bench for game_soc_multi_timer: a default 4x32-bit instance plus a 3x16-bit instance sharing one bus.
module tb_game_soc_multi_timer;

  localparam int AW_TB   = 6;
  localparam int OFF_ST  = 0;
  localparam int OFF_CT  = 1;
  localparam int OFF_P0  = 2;
  localparam int OFF_P1  = 3;
  localparam int OFF_S0  = 6;
  localparam int OFF_S1  = 7;
  localparam int OFF_PS  = 10;
  localparam int OFF_IRQ = 11;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW_TB-1:0] address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [15:0]      writedata  = '0;
  logic [15:0]      rdata1, rdata2;
  logic             irq1, irq2;

  game_soc_multi_timer dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rdata1),
    .irq        (irq1)
  );

  game_soc_multi_timer #(.NUM_CH(3), .CNT_W(16)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rdata2),
    .irq        (irq2)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
    end
  endtask

  // driver tasks: entered and left 1 time unit after a rising edge
  task automatic bus_write(input int ch, input int off, input logic [15:0] data);
    address    = AW_TB'(ch * 16 + off);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int sel, input int ch, input int off, input logic [15:0] exp,
                          input string tag);
    logic [15:0] got;
    exp_q.push_back(exp);
    address    = AW_TB'(ch * 16 + off);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    got = (sel != 0) ? rdata2 : rdata1;
    check_eq(tag, got, exp_q.pop_front());
  endtask

  task automatic idle_to(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int k;
    logic [31:0] exp32;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdata", rdata1, 16'h0000);
    check_eq("rst_irq", {15'b0, irq1}, 16'h0000);
    reset_n = 1'b1;

    // reset values
    bus_read(0, 0, OFF_P0, 16'hC34F, "t1_period0");
    bus_read(0, 0, OFF_P1, 16'h0000, "t1_period1");
    bus_read(0, 0, OFF_ST, 16'h0000, "t1_status");
    bus_read(1, 0, OFF_P0, 16'hC34F, "t1_cnt16_period0");
    bus_read(1, 0, OFF_P1, 16'h0000, "t1_cnt16_period1");
    check_eq("t1_irq", {15'b0, irq1}, 16'h0000);

    // ch1 continuous, period 9, every clock
    bus_write(1, OFF_P0, 16'd9);
    bus_write(1, OFF_PS, 16'd0);
    bus_write(1, OFF_CT, 16'h0007);
    s = cyc;
    idle_to(s + 8);
    bus_read(0, 1, OFF_ST, 16'h0002, "t2_before_to");
    bus_read(0, 1, OFF_ST, 16'h0003, "t2_to_set");
    check_eq("t2_irq_set", {15'b0, irq1}, 16'h0001);
    bus_read(0, 0, OFF_IRQ, 16'h0002, "t2_pend_win0");
    bus_read(0, 3, OFF_IRQ, 16'h0002, "t2_pend_win3");
    bus_write(1, OFF_ST, 16'h0000);
    check_eq("t2_irq_clr", {15'b0, irq1}, 16'h0000);
    bus_read(0, 1, OFF_ST, 16'h0002, "t2_status_clr");
    idle_to(s + 18);
    bus_read(0, 1, OFF_ST, 16'h0002, "t2_before_to2");
    bus_read(0, 1, OFF_ST, 16'h0003, "t2_to2_set");
    bus_write(1, OFF_ST, 16'h0000);
    idle_to(s + 28);
    bus_write(1, OFF_ST, 16'h0000);
    bus_read(0, 1, OFF_ST, 16'h0002, "t5_clear_beats_to");
    bus_read(0, 1, OFF_CT, 16'h0003, "t2_control_rb");
    bus_write(1, OFF_CT, 16'h0008);
    bus_read(0, 1, OFF_ST, 16'h0000, "t2_stopped");

    // ch2 one-shot, period 3, prescale 4
    bus_write(2, OFF_PS, 16'd4);
    bus_write(2, OFF_P0, 16'd3);
    bus_write(2, OFF_CT, 16'h0004);
    s = cyc;
    idle_to(s + 14);
    bus_read(0, 2, OFF_ST, 16'h0002, "t3_before_zero");
    bus_read(0, 2, OFF_ST, 16'h0003, "t3_zero_to");
    check_eq("t3_irq_masked", {15'b0, irq1}, 16'h0000);
    idle_to(s + 19);
    bus_read(0, 2, OFF_ST, 16'h0003, "t3_before_stop");
    bus_read(0, 2, OFF_ST, 16'h0001, "t3_oneshot_stop");
    idle_to(s + 26);
    bus_write(2, OFF_S0, 16'h0000);
    bus_read(0, 2, OFF_S0, 16'd3, "t3_snap_held");
    bus_read(0, 2, OFF_S1, 16'd0, "t3_snap_hi");
    bus_read(0, 2, OFF_PS, 16'd4, "t3_prescale_rb");
    bus_read(0, 1, OFF_IRQ, 16'h0000, "t3_pend_none");

    // ch0 period rewrite while running
    bus_write(0, OFF_P0, 16'd100);
    bus_write(0, OFF_CT, 16'h0004);
    s = cyc;
    bus_read(0, 0, OFF_ST, 16'h0002, "t4_start_beats_reload");
    idle_to(s + 10);
    bus_write(0, OFF_S0, 16'h0000);
    bus_read(0, 0, OFF_S0, 16'd90, "t4_snap_running");
    bus_write(0, OFF_P0, 16'd50);
    bus_read(0, 0, OFF_ST, 16'h0002, "t4_run_after_write");
    bus_write(0, OFF_S0, 16'h0000);
    bus_read(0, 0, OFF_ST, 16'h0000, "t4_run_cleared");
    bus_read(0, 0, OFF_S0, 16'd50, "t4_counter_reloaded");
    bus_read(0, 0, OFF_P0, 16'd50, "t4_period_rb");
    bus_write(0, OFF_CT, 16'h000C);
    bus_read(0, 0, OFF_ST, 16'h0002, "t4_start_beats_stop");

    // ch3 snapshot across a halfword borrow
    bus_write(3, OFF_P0, 16'h0000);
    bus_write(3, OFF_P1, 16'h0002);
    bus_write(3, OFF_CT, 16'h0006);
    s = cyc;
    k = $urandom_range(1, 30);
    idle_to(s + k - 1);
    bus_write(3, OFF_S0, 16'($urandom));
    exp32 = 32'h0002_0000 - 32'(k - 1);
    bus_read(0, 3, OFF_S0, exp32[15:0], "t5_snap_lo");
    bus_read(0, 3, OFF_S1, exp32[31:16], "t5_snap_hi");
    bus_read(0, 3, OFF_P1, 16'h0002, "t5_period1_rb");
    bus_read(0, 1, 13, 16'h0000, "t5_off13_zero");

    // reduced build: hole window and 16-bit counter
    bus_read(1, 3, OFF_P0, 16'h0000, "t6_hole_period0");
    bus_read(1, 3, OFF_ST, 16'h0000, "t6_hole_status");
    bus_read(1, 3, OFF_IRQ, 16'h0000, "t6_hole_pend");
    bus_read(1, 1, OFF_P0, 16'd9, "t6_cnt16_ch1_period0");
    bus_write(0, OFF_P1, 16'h1234);
    bus_read(1, 0, OFF_P1, 16'h0000, "t6_cnt16_period1_wr");
    bus_read(0, 0, OFF_P1, 16'h1234, "t6_cnt32_period1_wr");

    // asynchronous reset mid-count
    bus_write(1, OFF_CT, 16'h0007);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check_eq("t6_irq_before_rst", {15'b0, irq1}, 16'h0001);
    bus_read(0, 3, OFF_P1, 16'h0002, "t6_rdata_before_rst");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_rdata", rdata1, 16'h0000);
    check_eq("t6_rst_irq", {15'b0, irq1}, 16'h0000);
    check_eq("t6_rst_irq_cnt16", {15'b0, irq2}, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_read(0, 3, OFF_ST, 16'h0000, "t6_after_status");
    bus_read(0, 3, OFF_P0, 16'hC34F, "t6_after_period0");
    bus_read(0, 3, OFF_P1, 16'h0000, "t6_after_period1");
    bus_read(0, 2, OFF_PS, 16'h0000, "t6_after_prescale");
    bus_read(0, 1, OFF_CT, 16'h0000, "t6_after_control");
    bus_read(0, 3, OFF_S0, 16'h0000, "t6_after_snap");
    bus_read(0, 0, OFF_IRQ, 16'h0000, "t6_after_pend");
    bus_write(3, OFF_S0, 16'h0000);
    bus_read(0, 3, OFF_S0, 16'hC34F, "t6_after_counter");
    check_eq("t6_after_irq", {15'b0, irq1}, 16'h0000);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
